// File: rtl/collision_frame_sampler_if.sv
// Scan-side inputs and per-frame collision results of collision_frame_sampler.
// No backpressure: raster inputs are sampled every clk and results are registered levels plus a tick.
interface collision_frame_sampler_if #(
  parameter int CW = 10
);
  logic          enable;
  logic          valid;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          bouncing_object;
  logic [CW-1:0] ball_x;
  logic [CW-1:0] ball_y;
  logic          coll_x1;
  logic          coll_x2;
  logic          coll_y1;
  logic          coll_y2;
  logic          x_conflict;
  logic          frame_tick;
  logic [7:0]    frame_cnt;

  modport master (
    output enable, valid, h_cnt, v_cnt, bouncing_object, ball_x, ball_y,
    input  coll_x1, coll_x2, coll_y1, coll_y2, x_conflict, frame_tick, frame_cnt
  );

  modport slave (
    input  enable, valid, h_cnt, v_cnt, bouncing_object, ball_x, ball_y,
    output coll_x1, coll_x2, coll_y1, coll_y2, x_conflict, frame_tick, frame_cnt
  );
endinterface

// File: rtl/collision_frame_sampler.sv
// Latches ball-edge probe hits over a frame; commits them at the v_cnt==V_END rising edge.
// Results and frame_tick appear 2 clk after that edge; no backpressure, every clk is sampled.
module collision_frame_sampler #(
  parameter int CW        = 10,
  parameter int V_END     = 480,
  parameter int BALL_SIZE = 8,
  parameter int PROBE_OFF = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  collision_frame_sampler_if.slave bus
);

  localparam logic [0:0] ST_SCAN   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  localparam logic [CW:0]   BS = (CW+1)'(BALL_SIZE);
  localparam logic [CW:0]   PO = (CW+1)'(PROBE_OFF);
  localparam logic [CW-1:0] VE = CW'(V_END);

  logic [0:0] state_q, state_d;
  logic       vend_q, vend_d;
  logic [3:0] sticky_q, sticky_d;
  logic [3:0] coll_q, coll_d;
  logic       x_conflict_q, x_conflict_d;
  logic       frame_tick_q, frame_tick_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic [CW:0] hx, vy, bx, by, bx_size, bx_off, by_size, by_off;
  logic [3:0]  hit;
  logic [3:0]  hit_en;
  logic        at_vend;
  logic        commit_req;

  // One extra bit keeps ball+offset from wrapping back onto small raster coordinates.
  always_comb begin
    hx      = {1'b0, bus.h_cnt};
    vy      = {1'b0, bus.v_cnt};
    bx      = {1'b0, bus.ball_x};
    by      = {1'b0, bus.ball_y};
    bx_size = bx + BS;
    bx_off  = bx + PO;
    by_size = by + BS;
    by_off  = by + PO;
    hit     = 4'b0000;
    if (bus.bouncing_object && bus.valid) begin
      hit[0] = (hx == bx)      && (vy == by_off);
      hit[1] = (hx == bx_size) && (vy == by_off);
      hit[2] = (hx == bx_off)  && (vy == by);
      hit[3] = (hx == bx_off)  && (vy == by_size);
    end
    hit_en     = hit & {4{bus.enable}};
    at_vend    = (bus.v_cnt == VE);
    commit_req = at_vend && !vend_q;
  end

  always_comb begin
    state_d      = state_q;
    vend_d       = at_vend;
    sticky_d     = sticky_q;
    coll_d       = coll_q;
    x_conflict_d = x_conflict_q;
    frame_tick_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      ST_SCAN: begin
        sticky_d = sticky_q | hit_en;
        if (commit_req) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        coll_d       = sticky_q;
        x_conflict_d = sticky_q[0] & sticky_q[1];
        frame_tick_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        // A hit landing in the commit cycle seeds the next frame instead of being lost.
        sticky_d     = hit_en;
        state_d      = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SCAN;
      vend_q       <= 1'b0;
      sticky_q     <= 4'b0000;
      coll_q       <= 4'b0000;
      x_conflict_q <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      vend_q       <= vend_d;
      sticky_q     <= sticky_d;
      coll_q       <= coll_d;
      x_conflict_q <= x_conflict_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.coll_x1    = coll_q[0];
  assign bus.coll_x2    = coll_q[1];
  assign bus.coll_y1    = coll_q[2];
  assign bus.coll_y2    = coll_q[3];
  assign bus.x_conflict = x_conflict_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
